rx_temporal_cb_align: RTL and testbench
=======================================

# rx_temporal_cb_align

Lane-alignment controller for the RX temporal channel-bonding merge. It holds the round-robin merge in reset until every bonded lane is up and the head of every lane buffer sits on an alignment-marker beat. It then discards the marker round, releases the merge so it starts on lane 0, and monitors later marker rounds to detect loss of alignment. It sits beside the merge stage in the fast clock domain and drives the merge's reset and per-lane discard strobes.

## Interface
Parameters:
- `RATIO`, 2: number of bonded lanes; ≥2.
- `TIMEOUT`, 4096: maximum HUNT cycles before the controller declares failure and restarts.
- `ERR_THRESH`, 3: number of marker-order violations in LOCKED that forces a relock; ≥1.

Ports:
- `clk`  in  1  fast clock, shared with the merge.
- `rst`  in  1  reset; one clock; synchronous, active-high.
- `lane_up`  in  [RATIO]  per-lane link-up, already synchronized to `clk`.
- `head_valid`  in  [RATIO]  lane buffer head beat is valid.
- `head_is_marker`  in  [RATIO]  lane buffer head beat is an alignment marker; qualified by `head_valid`.
- `pop`  in  [RATIO]  merge consumed the lane head this cycle (`tvalid & tready` on the lane buffer output).
- `merge_rst`  out  1  holds the merge round-robin pointer at lane 0 and masks its output.
- `lane_discard`  out  [RATIO]  pops the lane head without forwarding it.
- `aligned`  out  1  high in LOCKED.
- `align_err`  out  1  one-cycle pulse on timeout or relock.
- `relock_cnt`  out  8  saturating count of relocks and timeouts.

## Operation
- States: DOWN, HUNT, LOCKED.
- **DOWN**
  - `merge_rst`=1, `lane_discard`=0.
  - When all `lane_up` bits are 1, go to HUNT and clear the timeout counter.
- **HUNT**
  - `merge_rst`=1.
  - Per lane, `lane_discard[i] = head_valid[i] & ~head_is_marker[i]`.
  - When every lane has `head_valid & head_is_marker`, assert `lane_discard` on all lanes for exactly that cycle and go to LOCKED.
  - The timeout counter increments each HUNT cycle. On reaching `TIMEOUT`: pulse `align_err`, increment `relock_cnt`, go to DOWN.
- **LOCKED**
  - `merge_rst`=0, `lane_discard`=0, `aligned`=1.
  - Marker-round check uses a RATIO-bit group mask (`grp`). A valid round is a marker pop on lane 0, then on lanes 1 through RATIO-1 in order, with no other pops in between.
  - Marker pop on lane 0 with `grp`=0: set `grp`=1.
  - Marker pop on lane i with `grp`=bits 0..i-1 set: set bit i. If i=RATIO-1, clear `grp`.
  - Violations:
    - marker pop on lane i≠0 with `grp`=0;
    - non-marker pop with `grp`≠0;
    - marker pop out of order;
    - more than one `pop` bit set in a cycle.
  - On a violation, clear `grp` and increment the violation counter (saturates at `ERR_THRESH`).
  - When the violation counter reaches `ERR_THRESH`: pulse `align_err`, increment `relock_cnt`, clear the violation counter, go to HUNT.
  - Any `lane_up` bit going to 0 sends the controller to DOWN. This does not pulse `align_err` and does not increment `relock_cnt`.
- The violation counter and `grp` are cleared on entry to LOCKED.
- Priority within a cycle: `rst` > lane-down > timeout or threshold > normal transition.

## Timing
- All outputs are registered.
- Reset values: state DOWN, `merge_rst`=1, `lane_discard`=0, `aligned`=0, `align_err`=0, `relock_cnt`=0, all counters 0.
- `rst` asserted mid-operation returns to DOWN on the next edge, whatever the state.
- DOWN→HUNT: one cycle after all `lane_up` bits are seen high.
- In HUNT, `lane_discard` is asserted the cycle after a non-marker head is seen. The lane buffer honours the discard in the same cycle it is asserted.
- The all-marker discard cycle and the LOCKED entry occur on the same edge. `merge_rst` falls one cycle after the markers are discarded.
- `relock_cnt` saturates at 255. The timeout counter width is `$clog2(TIMEOUT+1)`.

## Structure
- Shared package `rifl_cb_pkg`:
  - state enum `cb_align_state_t` (DOWN, HUNT, LOCKED);
  - the marker-round check helper.
- One sub-module, `cb_marker_checker`: `grp` tracking and violation detection, outputting a one-cycle `violation` pulse. The top level holds the FSM, counters and outputs.

## Test plan
- **Lane bring-up, RATIO=2:** `rst`; both lanes up; heads already markers.
  → One cycle with `lane_discard`=2'b11; `aligned`=1; `merge_rst` low one cycle later; `align_err` never pulses.
- **Skewed lanes:** lane 1 head presents 3 data beats before its marker; lane 0 head is a marker.
  → Exactly 3 `lane_discard[1]` pulses and none on lane 0; then joint discard; LOCKED.
- **No markers, TIMEOUT=16:** lanes up with no markers.
  → `align_err` pulses after 16 HUNT cycles; `relock_cnt`=1; DOWN, then HUNT again.
- **Marker order violations, ERR_THRESH=3:** in LOCKED, 3 marker pops on lane 1 with `grp`=0.
  → `align_err` pulses on the third; state HUNT; `merge_rst`=1; `relock_cnt` increments.
- **Lane drop:** `lane_up[0]` drops while LOCKED.
  → DOWN next cycle; `aligned`=0; `align_err`=0; `relock_cnt` unchanged.
- **Reset during HUNT and normal rounds:**
  - `rst` while discarding → all outputs at reset values next cycle.
  - In LOCKED, 100 correct marker rounds (lane 0 then lane 1) → no violations.

Source files
------------

// File: rtl/rifl_cb_pkg.sv
// Shared types and the marker-round ordering rule for the temporal channel-bonding aligner.
package rifl_cb_pkg;

  typedef enum logic [1:0] {
    DOWN   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } cb_align_state_t;

  localparam int CB_MAX_LANES = 16;

  // A marker on lane i is in sequence when exactly lanes 0..i-1 have already shown theirs.
  function automatic logic cb_marker_in_order(input logic [CB_MAX_LANES-1:0] grp, input int lane);
    logic [CB_MAX_LANES-1:0] w_expect;
    w_expect = CB_MAX_LANES'((64'd1 << lane) - 64'd1);
    return grp == w_expect;
  endfunction

endpackage

// File: rtl/rx_temporal_cb_align_if.sv
// Lane-buffer / merge side signals seen by the alignment controller.
interface rx_temporal_cb_align_if #(parameter int RATIO = 2);

  logic [RATIO-1:0] lane_up;
  logic [RATIO-1:0] head_valid;
  logic [RATIO-1:0] head_is_marker;
  logic [RATIO-1:0] pop;
  logic [RATIO-1:0] lane_discard;
  logic             merge_rst;
  logic             aligned;
  logic             align_err;
  logic [7:0]       relock_cnt;

  modport master (
    output lane_up, head_valid, head_is_marker, pop,
    input  lane_discard, merge_rst, aligned, align_err, relock_cnt
  );

  modport slave (
    input  lane_up, head_valid, head_is_marker, pop,
    output lane_discard, merge_rst, aligned, align_err, relock_cnt
  );

endinterface

// File: rtl/cb_marker_checker.sv
// Tracks marker rounds popped by the merge; flags an out-of-sequence pop combinationally.
module cb_marker_checker
  import rifl_cb_pkg::*;
#(
  parameter int RATIO = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_active,
  input  logic [RATIO-1:0] i_pop,
  input  logic [RATIO-1:0] i_marker,
  output logic             o_violation
);

  logic [RATIO-1:0] r_grp;
  logic [RATIO-1:0] w_grp_next;
  logic             w_violation;
  logic             w_multi;

  always_comb begin
    w_grp_next  = r_grp;
    w_violation = 1'b0;
    w_multi     = |(i_pop & (i_pop - RATIO'(1)));
    if (i_active && (|i_pop)) begin
      if (w_multi) begin
        w_violation = 1'b1;
        w_grp_next  = '0;
      end else begin
        for (int i = 0; i < RATIO; i++) begin
          if (i_pop[i]) begin
            if (i_marker[i]) begin
              if (cb_marker_in_order(CB_MAX_LANES'(r_grp), i)) begin
                w_grp_next = (i == RATIO - 1) ? '0 : (r_grp | (RATIO'(1) << i));
              end else begin
                w_violation = 1'b1;
                w_grp_next  = '0;
              end
            end else if (r_grp != '0) begin
              // data beat slipped into the middle of a marker round
              w_violation = 1'b1;
              w_grp_next  = '0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !i_active) begin
      r_grp <= '0;
    end else begin
      r_grp <= w_grp_next;
    end
  end

  assign o_violation = w_violation;

endmodule

// File: rtl/rx_temporal_cb_align.sv
// Lane-alignment controller: holds the merge in reset until all lanes sit on a marker,
// drops that marker round, then relocks on repeated round-order violations or hunt timeout.
module rx_temporal_cb_align
  import rifl_cb_pkg::*;
#(
  parameter int RATIO      = 2,
  parameter int TIMEOUT    = 4096,
  parameter int ERR_THRESH = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  rx_temporal_cb_align_if.slave  cb
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int VW = $clog2(ERR_THRESH + 1);

  cb_align_state_t  r_state;
  logic [TW-1:0]    r_tmo;
  logic [VW-1:0]    r_viol;
  logic             r_merge_rst;
  logic [RATIO-1:0] r_lane_discard;
  logic             r_aligned;
  logic             r_align_err;
  logic [7:0]       r_relock_cnt;

  logic             w_all_up;
  logic             w_all_marker;
  logic             w_violation;
  logic [TW-1:0]    w_tmo_next;
  logic [VW-1:0]    w_viol_next;
  logic [7:0]       w_relock_inc;

  assign w_all_up     = &cb.lane_up;
  assign w_all_marker = &(cb.head_valid & cb.head_is_marker);
  assign w_tmo_next   = r_tmo + TW'(1);
  assign w_viol_next  = r_viol + VW'(1);
  assign w_relock_inc = (r_relock_cnt == 8'hFF) ? r_relock_cnt : r_relock_cnt + 8'd1;

  cb_marker_checker #(.RATIO(RATIO)) u_checker (
    .clk         (clk),
    .rst         (rst),
    .i_active    (r_state == LOCKED),
    .i_pop       (cb.pop),
    .i_marker    (cb.head_valid & cb.head_is_marker),
    .o_violation (w_violation)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= DOWN;
      r_tmo          <= '0;
      r_viol         <= '0;
      r_merge_rst    <= 1'b1;
      r_lane_discard <= '0;
      r_aligned      <= 1'b0;
      r_align_err    <= 1'b0;
      r_relock_cnt   <= '0;
    end else begin
      r_align_err    <= 1'b0;
      r_lane_discard <= '0;
      case (r_state)
        DOWN: begin
          r_merge_rst <= 1'b1;
          r_aligned   <= 1'b0;
          if (w_all_up) begin
            r_state <= HUNT;
            r_tmo   <= '0;
          end
        end
        HUNT: begin
          if (!w_all_up) begin
            r_state <= DOWN;
          end else if (w_tmo_next == TW'(TIMEOUT)) begin
            r_state      <= DOWN;
            r_align_err  <= 1'b1;
            r_relock_cnt <= w_relock_inc;
          end else if (w_all_marker) begin
            r_state        <= LOCKED;
            r_lane_discard <= '1;
            r_aligned      <= 1'b1;
            r_viol         <= '0;
          end else begin
            r_tmo <= w_tmo_next;
            // a head already being dropped this cycle must not be dropped twice
            r_lane_discard <= cb.head_valid & ~cb.head_is_marker & ~r_lane_discard;
          end
        end
        LOCKED: begin
          if (!w_all_up) begin
            r_state     <= DOWN;
            r_merge_rst <= 1'b1;
            r_aligned   <= 1'b0;
          end else if (w_violation && (w_viol_next == VW'(ERR_THRESH))) begin
            r_state      <= HUNT;
            r_tmo        <= '0;
            r_viol       <= '0;
            r_align_err  <= 1'b1;
            r_relock_cnt <= w_relock_inc;
            r_merge_rst  <= 1'b1;
            r_aligned    <= 1'b0;
          end else begin
            r_merge_rst <= 1'b0;
            if (w_violation) begin
              r_viol <= w_viol_next;
            end
          end
        end
        default: r_state <= DOWN;
      endcase
    end
  end

  assign cb.merge_rst    = r_merge_rst;
  assign cb.lane_discard = r_lane_discard;
  assign cb.aligned      = r_aligned;
  assign cb.align_err    = r_align_err;
  assign cb.relock_cnt   = r_relock_cnt;

endmodule

// File: tb/tb_rx_temporal_cb_align.sv
// Randomized bench for rx_temporal_cb_align against a behavioural controller model
// and simple lane-buffer queues, plus directed bring-up, skew, timeout and relock cases.
module tb_rx_temporal_cb_align;

  localparam int RATIO      = 2;
  localparam int TIMEOUT    = 16;
  localparam int ERR_THRESH = 3;

  typedef enum int {M_DOWN, M_HUNT, M_LOCKED} mode_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rx_temporal_cb_align_if #(.RATIO(RATIO)) cb ();

  rx_temporal_cb_align #(
    .RATIO      (RATIO),
    .TIMEOUT    (TIMEOUT),
    .ERR_THRESH (ERR_THRESH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .cb  (cb)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // behavioural model of what the controller outputs must be next cycle
  mode_t            m_mode      = M_DOWN;
  int               m_age       = 0;
  int               m_viol      = 0;
  int               m_next      = 0;
  int               m_relock    = 0;
  logic             m_merge_rst = 1'b1;
  logic             m_aligned   = 1'b0;
  logic             m_err       = 1'b0;
  logic [RATIO-1:0] m_disc      = '0;

  // lane buffers: 1 = marker beat, 0 = data beat
  bit lq[RATIO][$];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // m_next is the lane whose marker is expected next; 0 means between rounds
  function automatic bit round_violation(input logic [RATIO-1:0] pp, input logic [RATIO-1:0] mk);
    int n;
    int k;
    n = $countones(pp);
    k = 0;
    if (n == 0) return 1'b0;
    if (n > 1) begin
      m_next = 0;
      return 1'b1;
    end
    for (int i = 0; i < RATIO; i++) if (pp[i]) k = i;
    if (mk[k]) begin
      if (k == m_next) begin
        m_next = (k + 1) % RATIO;
        return 1'b0;
      end
      m_next = 0;
      return 1'b1;
    end
    if (m_next != 0) begin
      m_next = 0;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_step(input bit r, input logic [RATIO-1:0] up, hv, hm, pp);
    logic [RATIO-1:0] prev_disc;
    prev_disc = m_disc;
    m_err  = 1'b0;
    m_disc = '0;
    if (r) begin
      m_mode = M_DOWN; m_merge_rst = 1'b1; m_aligned = 1'b0;
      m_relock = 0; m_age = 0; m_viol = 0; m_next = 0;
    end else if (m_mode == M_DOWN) begin
      if (up == '1) begin
        m_mode = M_HUNT;
        m_age  = 0;
      end
    end else if (up != '1) begin
      m_mode = M_DOWN; m_merge_rst = 1'b1; m_aligned = 1'b0;
    end else if (m_mode == M_HUNT) begin
      m_age++;
      if (m_age == TIMEOUT) begin
        m_err = 1'b1;
        m_relock = (m_relock < 255) ? m_relock + 1 : 255;
        m_mode = M_DOWN;
      end else if ((hv & hm) == '1) begin
        m_disc = '1; m_mode = M_LOCKED; m_aligned = 1'b1; m_viol = 0; m_next = 0;
      end else begin
        m_disc = hv & ~hm & ~prev_disc;
      end
    end else begin
      m_merge_rst = 1'b0;
      if (round_violation(pp, hv & hm)) begin
        m_viol++;
        if (m_viol == ERR_THRESH) begin
          m_err = 1'b1;
          m_relock = (m_relock < 255) ? m_relock + 1 : 255;
          m_viol = 0; m_mode = M_HUNT; m_age = 0;
          m_merge_rst = 1'b1; m_aligned = 1'b0;
        end
      end
    end
  endtask

  task automatic step(input bit r, input logic [RATIO-1:0] up, hv, hm, pp);
    logic [RATIO-1:0] disc_now;
    disc_now          = m_disc;
    rst               = r;
    cb.lane_up        = up;
    cb.head_valid     = hv;
    cb.head_is_marker = hm;
    cb.pop            = pp;
    model_step(r, up, hv, hm, pp);
    @(posedge clk);
    #1;
    chk("merge_rst",    cb.merge_rst,    m_merge_rst);
    chk("lane_discard", cb.lane_discard, m_disc);
    chk("aligned",      cb.aligned,      m_aligned);
    chk("align_err",    cb.align_err,    m_err);
    chk("relock_cnt",   cb.relock_cnt,   m_relock);
    for (int i = 0; i < RATIO; i++) begin
      if (disc_now[i] && lq[i].size() != 0) void'(lq[i].pop_front());
    end
  endtask

  task automatic qstep(input logic [RATIO-1:0] up);
    logic [RATIO-1:0] hv;
    logic [RATIO-1:0] hm;
    for (int i = 0; i < RATIO; i++) begin
      hv[i] = (lq[i].size() != 0);
      hm[i] = hv[i] && lq[i][0];
    end
    step(1'b0, up, hv, hm, '0);
  endtask

  task automatic clear_queues();
    for (int i = 0; i < RATIO; i++) lq[i].delete();
  endtask

  initial begin
    int n;
    int l0;
    int l1;
    int errs;
    logic [RATIO-1:0] up;
    logic [RATIO-1:0] hm;
    logic [RATIO-1:0] pp;
    bit r;

    cb.lane_up = '0; cb.head_valid = '0; cb.head_is_marker = '0; cb.pop = '0;

    // reset values
    step(1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
    step(1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
    chk("rst_merge_rst", cb.merge_rst, 1);
    chk("rst_discard",   cb.lane_discard, 0);
    chk("rst_aligned",   cb.aligned, 0);
    chk("rst_relock",    cb.relock_cnt, 0);
    repeat (3) step(1'b0, 2'b01, 2'b00, 2'b00, 2'b00);

    // bring-up with markers already at the heads
    lq[0].push_back(1'b1); lq[0].push_back(1'b0);
    lq[1].push_back(1'b1); lq[1].push_back(1'b0);
    n = 0;
    while (m_mode != M_LOCKED && n < 30) begin qstep(2'b11); n++; end
    chk("bringup_lock_cycles", n, 2);
    chk("bringup_joint_discard", cb.lane_discard, 2'b11);
    chk("bringup_aligned", cb.aligned, 1);
    chk("bringup_merge_rst_held", cb.merge_rst, 1);
    qstep(2'b11);
    chk("bringup_merge_rst_fall", cb.merge_rst, 0);
    chk("bringup_no_err", cb.relock_cnt, 0);
    clear_queues();

    // 100 correct rounds with idle gaps and inter-round data pops
    errs = 0;
    for (int rd = 0; rd < 100; rd++) begin
      repeat ($urandom_range(0, 2)) step(1'b0, 2'b11, 2'b11, 2'b00, 2'b00);
      if ($urandom_range(0, 1) == 1) begin
        pp = 2'b01 << $urandom_range(0, 1);
        step(1'b0, 2'b11, 2'b11, 2'b00, pp);
        errs += cb.align_err;
      end
      step(1'b0, 2'b11, 2'b11, 2'b01, 2'b01);
      errs += cb.align_err;
      repeat ($urandom_range(0, 2)) step(1'b0, 2'b11, 2'b11, 2'b00, 2'b00);
      step(1'b0, 2'b11, 2'b11, 2'b10, 2'b10);
      errs += cb.align_err;
    end
    chk("rounds_err_pulses", errs, 0);
    chk("rounds_aligned", cb.aligned, 1);

    // three lane-1 markers with no round open
    step(1'b0, 2'b11, 2'b11, 2'b10, 2'b10);
    chk("viol1_no_err", cb.align_err, 0);
    step(1'b0, 2'b11, 2'b11, 2'b00, 2'b00);
    step(1'b0, 2'b11, 2'b11, 2'b10, 2'b10);
    chk("viol2_no_err", cb.align_err, 0);
    step(1'b0, 2'b11, 2'b11, 2'b10, 2'b10);
    chk("viol3_err", cb.align_err, 1);
    chk("viol3_aligned", cb.aligned, 0);
    chk("viol3_merge_rst", cb.merge_rst, 1);
    chk("viol3_relock", cb.relock_cnt, 1);

    // skewed lanes: lane 1 has three data beats ahead of its marker
    lq[0].push_back(1'b1);
    repeat (3) lq[1].push_back(1'b0);
    lq[1].push_back(1'b1);
    n = 0; l0 = 0; l1 = 0;
    while (m_mode != M_LOCKED && n < 30) begin
      qstep(2'b11);
      n++;
      if (m_mode != M_LOCKED) begin
        l0 += int'(cb.lane_discard[0]);
        l1 += int'(cb.lane_discard[1]);
      end
    end
    chk("skew_lock_cycles", n, 7);
    chk("skew_lane0_discards", l0, 0);
    chk("skew_lane1_discards", l1, 3);
    chk("skew_joint_discard", cb.lane_discard, 2'b11);
    qstep(2'b11);
    qstep(2'b11);
    chk("skew_locked_merge_rst", cb.merge_rst, 0);
    clear_queues();

    // lane 0 drops while locked
    step(1'b0, 2'b10, 2'b11, 2'b00, 2'b00);
    chk("drop_aligned", cb.aligned, 0);
    chk("drop_err", cb.align_err, 0);
    chk("drop_relock", cb.relock_cnt, 1);
    chk("drop_merge_rst", cb.merge_rst, 1);

    // no markers at all: hunt times out
    n = 0;
    do begin
      step(1'b0, 2'b11, 2'b11, 2'b00, 2'b00);
      n++;
    end while (cb.align_err != 1'b1 && n < 40);
    chk("timeout_cycles", n, 17);
    chk("timeout_relock", cb.relock_cnt, 2);
    step(1'b0, 2'b11, 2'b11, 2'b00, 2'b00);
    chk("timeout_down_discard", cb.lane_discard, 0);
    step(1'b0, 2'b11, 2'b11, 2'b00, 2'b00);
    chk("rehunt_discard", cb.lane_discard, 2'b11);

    // reset while discarding
    step(1'b1, 2'b11, 2'b11, 2'b00, 2'b00);
    chk("midrst_merge_rst", cb.merge_rst, 1);
    chk("midrst_discard", cb.lane_discard, 0);
    chk("midrst_aligned", cb.aligned, 0);
    chk("midrst_err", cb.align_err, 0);
    chk("midrst_relock", cb.relock_cnt, 0);

    // randomized traffic, biased toward legal rounds
    for (int c = 0; c < 1500; c++) begin
      r  = ($urandom_range(0, 499) == 0);
      up = ($urandom_range(0, 99) == 0) ? 2'($urandom) : 2'b11;
      hm = '0;
      pp = '0;
      if (m_mode == M_LOCKED) begin
        if ($urandom_range(0, 9) < 7) begin
          if ($urandom_range(0, 2) != 0) begin
            pp = 2'b01 << m_next;
            hm = pp;
          end
        end else begin
          pp = 2'($urandom);
          hm = 2'($urandom);
        end
      end else begin
        for (int i = 0; i < RATIO; i++) hm[i] = ($urandom_range(0, 2) == 0);
      end
      step(r, up, 2'b11, hm, pp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
